// File: rtl/ttl_irq_enc_pkg.sv
// rtl/ttl_irq_enc_pkg.sv - shared constants, types and priority helper for the 74148-style IRQ encoder
//
// Contents:
//   NREQ       number of request lines (8, 74148 width)
//   CODE_W     encoded index width (3)
//   CODE_IDLE  code_n value when nothing is encoded
//   prio_t     {found, idx} result of a priority search
//   prio_find  highest set bit of an active-high vector
package ttl_irq_enc_pkg;

    localparam int NREQ   = 8;
    localparam int CODE_W = 3;

    localparam logic [CODE_W-1:0] CODE_IDLE = 3'b111;

    typedef struct packed {
        logic              found;
        logic [CODE_W-1:0] idx;
    } prio_t;

    // Ascending scan: a later (higher) set bit overwrites an earlier one,
    // so the highest index wins.
    function automatic prio_t prio_find(input logic [NREQ-1:0] v);
        prio_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                r.found = 1'b1;
                r.idx   = CODE_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ttl_74148_nodly.sv
// rtl/ttl_74148_nodly.sv - combinational 8-to-3 priority encoder in 74148 polarity
//
// Ports:
//   i_n   in  [7:0]  active-low inputs, bit 7 highest priority
//   ei_n  in         enable input; 1 forces all outputs high
//   a_n   out [2:0]  inverted index of highest active input
//   gs_n  out        0 when ei_n=0 and any input active
//   eo_n  out        0 when ei_n=0 and no input active (cascade)
module ttl_74148_nodly
    import ttl_irq_enc_pkg::*;
(
    input  logic [NREQ-1:0]   i_n,
    input  logic              ei_n,
    output logic [CODE_W-1:0] a_n,
    output logic              gs_n,
    output logic              eo_n
);

    prio_t hit;

    always_comb begin
        hit  = prio_find(~i_n);
        a_n  = CODE_IDLE;
        gs_n = 1'b1;
        eo_n = 1'b1;
        if (!ei_n) begin
            if (hit.found) begin
                a_n  = ~hit.idx;
                gs_n = 1'b0;
            end else begin
                eo_n = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ttl_74148_irq_enc.sv
// rtl/ttl_74148_irq_enc.sv - registered 8-to-3 priority IRQ encoder with latched falling-edge requests
//
// Build option: TTL_IRQ_ENC_SYNC_EN adds a 2-flop synchronizer on req_n
// (needed when request sources are asynchronous to clk).
//
// Ports:
//   clk      in         system clock
//   reset_n  in         asynchronous active-low reset
//   req_n    in  [7:0]  active-low request strobes, falling edge latches pending
//   mask     in  [7:0]  1 = line takes part in encoding
//   ei_n     in         enable; 1 idles all encoder outputs
//   ack      in         clears the pending bit currently shown on code_n
//   code_n   out [2:0]  inverted index of highest unmasked pending line
//   gs_n     out        0 when code_n is valid
//   eo_n     out        0 when enabled and nothing unmasked is pending
//   irq_n    out        interrupt, low while gs_n is low
//   pending  out [7:0]  raw pending register
module ttl_74148_irq_enc
    import ttl_irq_enc_pkg::*;
#(
    parameter int              NREQ     = 8,
    parameter logic [NREQ-1:0] PEND_RST = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_n,
    input  logic [NREQ-1:0]   mask,
    input  logic              ei_n,
    input  logic              ack,
    output logic [CODE_W-1:0] code_n,
    output logic              gs_n,
    output logic              eo_n,
    output logic              irq_n,
    output logic [NREQ-1:0]   pending
);

    logic [NREQ-1:0]   samp;
    logic [NREQ-1:0]   samp_prev;
    logic [NREQ-1:0]   edge_det;
    logic [NREQ-1:0]   clr;
    logic [NREQ-1:0]   pend_nxt;
    logic [CODE_W-1:0] enc_code_n;
    logic              enc_gs_n;
    logic              enc_eo_n;

`ifdef TTL_IRQ_ENC_SYNC_EN
    logic [NREQ-1:0] sync1;
    logic [NREQ-1:0] sync2;

    // Reset high so that no edge is invented while leaving reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= req_n;
            sync2 <= sync1;
        end
    end

    assign samp = sync2;
`else
    assign samp = req_n;
`endif

    // Previous sample resets high: a line already low at reset release
    // is treated as a fresh request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_prev <= '1;
        end else begin
            samp_prev <= samp;
        end
    end

    assign edge_det = samp_prev & ~samp;

    // Ack acts on the registered code, so a held ack hits each line once
    // and then idles a cycle while the outputs catch up.
    always_comb begin
        clr = '0;
        if (ack && !gs_n) begin
            clr[~code_n] = 1'b1;
        end
    end

    // Set after clear: a new edge on the line being acknowledged survives.
    assign pend_nxt = (pending & ~clr) | edge_det;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= PEND_RST;
        end else begin
            pending <= pend_nxt;
        end
    end

    ttl_74148_nodly u_enc (
        .i_n  (~(pending & mask)),
        .ei_n (ei_n),
        .a_n  (enc_code_n),
        .gs_n (enc_gs_n),
        .eo_n (enc_eo_n)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_n <= CODE_IDLE;
            gs_n   <= 1'b1;
            eo_n   <= 1'b1;
            irq_n  <= 1'b1;
        end else begin
            code_n <= enc_code_n;
            gs_n   <= enc_gs_n;
            eo_n   <= enc_eo_n;
            irq_n  <= enc_gs_n;
        end
    end

endmodule

// File: doc/ttl_74148_irq_enc.md
Name: ttl_74148_irq_enc

Overview:
- Registered 8-to-3 priority encoder with latched requests. It is the encode-side counterpart of the board's 2-to-4 active-low decoders.
- Collects active-low request strobes from board logic (VBLANK, sound, sprite DMA, comms), latches falling edges as pending, and presents the highest-priority unmasked pending line as a 74148-style inverted code plus an interrupt line.
- Sits between peripheral glue and the CPU interrupt/vector logic. The CPU side acknowledges and clears one request at a time.

Parameters:
- NREQ, 8, number of request lines; fixed at 8 for 74148 compatibility (code width 3).
- PEND_RST, 8'h00, reset value of the pending register.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- req_n  input  8  active-low request strobes; a falling edge sets pending; may be asynchronous to clk
- mask  input  8  1 = line enabled for encoding; level, sampled every cycle
- ei_n  input  1  74148 enable input; 1 = encoder outputs deasserted
- ack  input  1  single-cycle acknowledge; clears the pending bit currently encoded
- code_n  output  3  inverted index of highest-priority unmasked pending line (bit 7 highest)
- gs_n  output  1  0 when code_n is valid (any unmasked pending and ei_n=0)
- eo_n  output  1  0 when ei_n=0 and no unmasked pending (cascade out)
- irq_n  output  1  0 while gs_n=0; registered copy of gs_n
- pending  output  8  raw pending register, for debug

Behaviour:
- Reset (async assert, sync release):
  - pending=PEND_RST.
  - Edge-detect and synchronizer flops=1.
  - code_n=3'b111, gs_n=1, eo_n=1, irq_n=1.
- Edge detect: a line is detected when the current sample is 0 and the previous sample is 1.
  - A line held low across reset release is seen as a falling edge and is captured.
  - Holding a line low does not retrigger. It must return high for at least one sample before the next edge is seen.
- Pending: bit i is set on a detected edge and stays set until acknowledged. Mask does not affect pending capture; a masked line stays latched and is encoded once unmasked.
- Encoding: combinational priority over (pending & mask), highest index wins. Result registered into code_n/gs_n/eo_n/irq_n.
  - All four outputs are registered and change together on one clock edge.
- ei_n=1 forces code_n=111, gs_n=1, eo_n=1, irq_n=1 on the next edge; pending is unaffected.
- ack:
  - Clears pending[~code_n] when sampled while gs_n=0. Outputs update one cycle later, showing the next pending line or going idle.
  - Ignored while gs_n=1.
  - Multi-cycle ack: each cycle acts on the then-current registered code. Holding ack high therefore drains one line per two cycles; software must pulse.
- Simultaneous set and clear of the same bit in one cycle: set wins and the bit stays pending.
- Latency, with sample edge N = first rising edge at which req_n[i] is low:
  - With synchronizer: pending set at N+2, outputs valid after N+3.
  - Without synchronizer: pending set at N, outputs valid after N+1.
- Reset mid-operation: all pending requests are lost and outputs return to idle immediately, asynchronously.

Optional Feature:
- Macro TTL_IRQ_ENC_SYNC_EN.
- Defined: req_n passes through a 2-flop synchronizer before edge detect, adding 2 cycles of latency. Required when req_n sources are asynchronous.
- Undefined: req_n feeds the edge detector directly; only valid for clk-synchronous sources.

Decomposition:
- Package ttl_irq_enc_pkg holds:
  - NREQ and CODE_W=3.
  - Idle output constants (CODE_IDLE=3'b111).
  - The priority function.
- One natural sub-module: ttl_74148_nodly, a combinational 8-to-3 priority encoder with ei_n/gs_n/eo_n in 74148 polarity. The top adds synchronizer, edge detect, pending, ack and output registers.

Test Plan:
- Reset release with req_n=8'hFF, mask=8'hFF, ei_n=0: code_n=111, gs_n=1, eo_n=0, irq_n=1; pending=0.
- req_n[2] pulsed low 1 cycle (sync on): from edge N+3, code_n=3'b101, gs_n=0, irq_n=0, eo_n=1. Ack pulse: next cycle gs_n=1, eo_n=0, pending=0.
- Edges on lines 1, 5 and 7 in the same cycle: code_n=000 (line 7). Ack gives 010 (line 5); ack gives 110 (line 1); ack gives idle.
- mask=8'h7F with a line-7 edge: pending[7]=1, gs_n=1. Set mask=8'hFF: code_n=000 one cycle later.
- New line-3 edge lands in the same cycle as ack of line 3: pending[3] stays 1 and code_n stays 100.
- ei_n=1 with pending line 4: gs_n=1, eo_n=1, code_n=111. ei_n=0: code_n=011. Assert reset_n=0 mid-cycle: outputs idle immediately, pending cleared.
